// File: rtl/usb_rx_pkg.sv
// ============================================================================
// Module   : usb_rx_pkg
// Brief    : Shared types and constants for the full-speed USB receive path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    EOP   = 3'd3,
    ERROR = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2
  } line_state_e;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;

  // Both (0,0) and the illegal (1,1) pair are reported as SE0.
  function automatic line_state_e decode_line(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return LS_J;
      2'b01:   return LS_K;
      default: return LS_SE0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_rx_bit_timer.sv
// ============================================================================
// Module   : usb_rx_bit_timer
// Brief    : Bit-time counter with synchronous clear; strobes at mid-bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_strobe
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == TW'(CLKS_PER_BIT - 1))) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_strobe = (r_cnt == TW'(CLKS_PER_BIT / 2 - 1));

endmodule

`default_nettype wire

// File: rtl/usb_rx_decoder.sv
// ============================================================================
// Module   : usb_rx_decoder
// Brief    : Full-speed USB RX front end: NRZI decode, unstuff, SYNC/EOP, bytes.
//            Define USB_RX_STUFF_ERR_EN to treat a 1 in a stuff slot as an error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dp_in,
  input  logic       dm_in,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_packet_start,
  output logic       rx_packet_done,
  output logic       rx_error,
  output logic       rx_busy
);

  rx_state_e   r_state,    w_state_nxt;
  line_state_e r_prev_ls,  w_prev_ls_nxt;
  logic [7:0]  r_shift,    w_shift_nxt;
  logic [2:0]  r_bit_idx,  w_bit_idx_nxt;
  logic [2:0]  r_ones,     w_ones_nxt;
  logic        r_se0_seen, w_se0_seen_nxt;
  logic [7:0]  r_rx_data,  w_rx_data_nxt;
  logic        r_valid,    w_valid_nxt;
  logic        r_start,    w_start_nxt;
  logic        r_done,     w_done_nxt;
  logic        r_err,      w_err_nxt;
  logic [1:0]  r_prev_pair;

  line_state_e w_ls;
  logic        w_timer_clr;
  logic        w_strobe;
  logic        w_bit;
  logic [7:0]  w_shifted;

  assign w_ls        = decode_line(dp_in, dm_in);
  assign w_timer_clr = ({dp_in, dm_in} != r_prev_pair) || ((r_state == IDLE) && (w_ls == LS_K));
  assign w_bit       = (w_ls == r_prev_ls);
  assign w_shifted   = {w_bit, r_shift[7:1]};

  usb_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_timer_clr),
    .o_strobe(w_strobe)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_prev_ls_nxt  = r_prev_ls;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_ones_nxt     = r_ones;
    w_se0_seen_nxt = r_se0_seen;
    w_rx_data_nxt  = r_rx_data;
    w_valid_nxt    = 1'b0;
    w_start_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      IDLE: begin
        w_prev_ls_nxt = LS_J;
        if (w_ls == LS_K) begin
          w_state_nxt   = SYNC;
          w_bit_idx_nxt = 3'd0;
          w_shift_nxt   = 8'h00;
        end
      end

      SYNC: begin
        if (w_strobe) begin
          w_prev_ls_nxt = w_ls;
          if (w_ls == LS_SE0) begin
            w_state_nxt = ERROR;
          end else begin
            w_shift_nxt   = w_shifted;
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              if (w_shifted == SYNC_PATTERN) begin
                // The final SYNC 1 starts the run that bit stuffing tracks.
                w_state_nxt   = DATA;
                w_start_nxt   = 1'b1;
                w_ones_nxt    = 3'd1;
                w_bit_idx_nxt = 3'd0;
              end else begin
                w_state_nxt = ERROR;
              end
            end
          end
        end
      end

      DATA: begin
        if (w_strobe) begin
          w_prev_ls_nxt = w_ls;
          if (w_ls == LS_SE0) begin
            w_se0_seen_nxt = 1'b0;
            w_state_nxt    = (r_bit_idx == 3'd0) ? EOP : ERROR;
          end else if (r_ones == STUFF_LIMIT) begin
            w_ones_nxt = 3'd0;
`ifdef USB_RX_STUFF_ERR_EN
            if (w_bit) begin
              w_state_nxt = ERROR;
            end
`endif
          end else begin
            w_shift_nxt   = w_shifted;
            w_ones_nxt    = w_bit ? (r_ones + 3'd1) : 3'd0;
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              w_rx_data_nxt = w_shifted;
              w_valid_nxt   = 1'b1;
            end
          end
        end
      end

      EOP: begin
        // r_se0_seen marks that the second SE0 bit has been sampled.
        if (w_strobe) begin
          w_prev_ls_nxt = w_ls;
          case (w_ls)
            LS_SE0: begin
              if (r_se0_seen) begin
                w_state_nxt = ERROR;
              end else begin
                w_se0_seen_nxt = 1'b1;
              end
            end
            LS_J: begin
              if (r_se0_seen) begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
              end else begin
                w_state_nxt = ERROR;
              end
            end
            default: w_state_nxt = ERROR;
          endcase
        end
      end

      ERROR: begin
        if (w_strobe) begin
          w_prev_ls_nxt = w_ls;
          case (w_ls)
            LS_SE0:  w_se0_seen_nxt = 1'b1;
            LS_J:    if (r_se0_seen) w_state_nxt = IDLE;
            default: w_se0_seen_nxt = 1'b0;
          endcase
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    // An SE0 that causes the error already counts toward the recovery SE0,J.
    if ((w_state_nxt == ERROR) && (r_state != ERROR)) begin
      w_err_nxt      = 1'b1;
      w_se0_seen_nxt = (w_ls == LS_SE0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_prev_ls   <= LS_J;
      r_prev_pair <= 2'b10;
      r_shift     <= 8'h00;
      r_bit_idx   <= 3'd0;
      r_ones      <= 3'd0;
      r_se0_seen  <= 1'b0;
      r_rx_data   <= 8'h00;
      r_valid     <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_ls   <= w_prev_ls_nxt;
      r_prev_pair <= {dp_in, dm_in};
      r_shift     <= w_shift_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_ones      <= w_ones_nxt;
      r_se0_seen  <= w_se0_seen_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_valid     <= w_valid_nxt;
      r_start     <= w_start_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign rx_data         = r_rx_data;
  assign rx_data_valid   = r_valid;
  assign rx_packet_start = r_start;
  assign rx_packet_done  = r_done;
  assign rx_error        = r_err;
  assign rx_busy         = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_usb_rx_decoder.sv
// ============================================================================
// Module   : tb_usb_rx_decoder
// Brief    : Self-checking bench for usb_rx_decoder (tables, sequences, random).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_usb_rx_decoder;

  localparam int CPB = 8;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic       dp_in, dm_in;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_packet_start, rx_packet_done, rx_error, rx_busy;

  usb_rx_decoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst            (rst),
    .dp_in          (dp_in),
    .dm_in          (dm_in),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_packet_start(rx_packet_start),
    .rx_packet_done (rx_packet_done),
    .rx_error       (rx_error),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] got_q[$];
  int n_start = 0, n_done = 0, n_err = 0, n_wide = 0;
  logic p_v = 1'b0, p_s = 1'b0, p_d = 1'b0, p_e = 1'b0;
  logic [1:0] sym_q[$];

  // Pulse monitor: collects bytes and counts strobes, flags any strobe wider than one clk.
  always @(negedge clk) begin
    if (rst) begin
      p_v = 1'b0; p_s = 1'b0; p_d = 1'b0; p_e = 1'b0;
    end else begin
      if (rx_data_valid)   got_q.push_back(rx_data);
      if (rx_packet_start) n_start++;
      if (rx_packet_done)  n_done++;
      if (rx_error)        n_err++;
      if ((rx_data_valid && p_v) || (rx_packet_start && p_s) ||
          (rx_packet_done && p_d) || (rx_error && p_e)) n_wide++;
      p_v = rx_data_valid; p_s = rx_packet_start; p_d = rx_packet_done; p_e = rx_error;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter model: SYNC, LSB-first data with a stuff bit after six ones, NRZI, EOP.
  task automatic build_packet(input logic [31:0] data, input int nbits, input bit stuff_one);
    bit         bits[$];
    bit         b;
    int         ones;
    logic [1:0] lvl;
    bits = {};
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    ones = 1;
    for (int i = 0; i < nbits; i++) begin
      b = data[i];
      if (ones == 6) begin
        bits.push_back(stuff_one);
        ones = 0;
      end
      bits.push_back(b);
      ones = b ? ones + 1 : 0;
    end
    sym_q = {};
    lvl = LJ;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = (lvl == LJ) ? LK : LJ;
      sym_q.push_back(lvl);
    end
    sym_q.push_back(LSE0);
    sym_q.push_back(LSE0);
    sym_q.push_back(LJ);
  endtask

  task automatic drive(input int nsym, input bit drift);
    int dur;
    for (int i = 0; i < nsym && i < sym_q.size(); i++) begin
      dur = drift ? ((i % 2 == 0) ? 7 : 9) : CPB;
      {dp_in, dm_in} = sym_q[i];
      repeat (dur) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int n);
    {dp_in, dm_in} = LJ;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_check(input string name, input logic [31:0] data, input int nbits,
                            input bit stuff_one, input bit drift, input int exp_n,
                            input logic [31:0] exp_data, input int exp_start,
                            input int exp_done, input int exp_err);
    int base, s0, d0, e0;
    base = got_q.size(); s0 = n_start; d0 = n_done; e0 = n_err;
    build_packet(data, nbits, stuff_one);
    drive(sym_q.size(), drift);
    idle_bits(4);
    check($sformatf("%s.nvalid", name), got_q.size() - base, exp_n);
    for (int i = 0; i < exp_n && (base + i) < got_q.size(); i++)
      check($sformatf("%s.byte%0d", name, i), got_q[base + i], exp_data[8*i +: 8]);
    check($sformatf("%s.start", name), n_start - s0, exp_start);
    check($sformatf("%s.done", name),  n_done - d0,  exp_done);
    check($sformatf("%s.error", name), n_err - e0,   exp_err);
    check($sformatf("%s.busy", name),  rx_busy,      0);
  endtask

  typedef struct {
    logic [31:0] data;
    int          nbits;
    bit          stuff_one;
    bit          drift;
    int          exp_n;
    logic [31:0] exp_data;
    int          exp_start;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vt[6];

  initial begin
    int nb, nbits, s0, d0, e0;
    logic [31:0] data;
    bit trunc, drift;

    vt[0] = '{32'h0000_3CA5, 16, 1'b0, 1'b0, 2, 32'h0000_3CA5, 1, 1, 0};
    vt[1] = '{32'h0000_00FF,  8, 1'b0, 1'b0, 1, 32'h0000_00FF, 1, 1, 0};
`ifdef USB_RX_STUFF_ERR_EN
    vt[2] = '{32'h0000_00FF,  8, 1'b1, 1'b0, 0, 32'h0000_0000, 1, 0, 1};
`else
    vt[2] = '{32'h0000_00FF,  8, 1'b1, 1'b0, 1, 32'h0000_00FF, 1, 1, 0};
`endif
    vt[3] = '{32'h0FF0_5A81, 32, 1'b0, 1'b1, 4, 32'h0FF0_5A81, 1, 1, 0};
    vt[4] = '{32'h0000_00C3, 12, 1'b0, 1'b0, 1, 32'h0000_00C3, 1, 0, 1};
    vt[5] = '{32'h00FF_007E, 24, 1'b0, 1'b0, 3, 32'h00FF_007E, 1, 1, 0};

    rst = 1'b1;
    {dp_in, dm_in} = LJ;
    repeat (3) @(negedge clk);
    check("reset.rx_data",  rx_data,         0);
    check("reset.valid",    rx_data_valid,   0);
    check("reset.start",    rx_packet_start, 0);
    check("reset.done",     rx_packet_done,  0);
    check("reset.error",    rx_error,        0);
    check("reset.busy",     rx_busy,         0);
    rst = 1'b0;
    idle_bits(2);

    foreach (vt[i])
      send_check($sformatf("vec%0d", i), vt[i].data, vt[i].nbits, vt[i].stuff_one,
                 vt[i].drift, vt[i].exp_n, vt[i].exp_data, vt[i].exp_start,
                 vt[i].exp_done, vt[i].exp_err);

    // Bad SYNC: error, then ERROR holds across idle J until SE0,J.
    s0 = n_start; d0 = n_done; e0 = n_err;
    sym_q = {LK, LJ, LK, LJ, LK, LJ, LK, LJ};
    drive(8, 1'b0);
    idle_bits(3);
    check("badsync.error", n_err - e0,   1);
    check("badsync.start", n_start - s0, 0);
    check("badsync.held",  rx_busy,      1);
    sym_q = {LSE0, LJ};
    drive(2, 1'b0);
    idle_bits(2);
    check("badsync.busy", rx_busy,     0);
    check("badsync.done", n_done - d0, 0);

    // Reset after SYNC plus four data bits.
    build_packet(32'h0000_00A5, 8, 1'b0);
    drive(12, 1'b0);
    check("midreset.busy_before", rx_busy, 1);
    #2 rst = 1'b1;
    #1;
    check("midreset.rx_data", rx_data,         0);
    check("midreset.busy",    rx_busy,         0);
    check("midreset.valid",   rx_data_valid,   0);
    check("midreset.start",   rx_packet_start, 0);
    {dp_in, dm_in} = LJ;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_bits(4);
    send_check("after_reset", 32'h0000_005A, 8, 1'b0, 1'b0, 1, 32'h0000_005A, 1, 1, 0);
    check("after_reset.rx_data", rx_data, 8'h5A);

    // Random packets, some truncated mid-byte; expected bytes = whole bytes sent.
    for (int r = 0; r < 12; r++) begin
      nb    = $urandom_range(1, 4);
      data  = $urandom;
      trunc = $urandom_range(0, 1);
      nbits = trunc ? $urandom_range(1, nb * 8 - 1) : nb * 8;
      trunc = (nbits % 8) != 0;
      drift = $urandom_range(0, 1);
      send_check($sformatf("rand%0d", r), data, nbits, 1'b0, drift, nbits / 8, data,
                 1, trunc ? 0 : 1, trunc ? 1 : 0);
    end

    check("pulse_width", n_wide, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
